// File: rtl/swt16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swt16_pkg
// Description : Widths, opcodes and memaccess state encoding shared by the
//               swt16 pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package swt16_pkg;

  localparam int OPCODE_WIDTH    = 4;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int PC_WIDTH        = 12;
  localparam int IALU_WORD_WIDTH = 16;
  localparam int REG_IDX_WIDTH   = 4;
  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_WORD_WIDTH = 16;
  localparam int TIMEOUT_CYCLES  = 255;

  localparam logic [3:0] OPC_LOAD  = 4'hA;
  localparam logic [3:0] OPC_STORE = 4'hB;

  typedef enum logic [0:0] {
    MA_IDLE = 1'b0,
    MA_REQ  = 1'b1
  } ma_state_e;

endpackage
`default_nettype wire

// File: rtl/memaccess_if.sv
`default_nettype none
// ============================================================================
// Module      : memaccess_if
// Description : Data-memory req/ack bus between memaccess (master) and the
//               data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memaccess_if
  import swt16_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_WIDTH,
  parameter int DATA_W = DMEM_WORD_WIDTH
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface
`default_nettype wire

// File: rtl/memaccess_timeout.sv
`default_nettype none
// ============================================================================
// Module      : memaccess_timeout
// Description : Clear/enable wait counter; tc_o marks the last allowed wait
//               cycle so the FSM can give up on the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module memaccess_timeout #(
  parameter int TIMEOUT_CYCLES = swt16_pkg::TIMEOUT_CYCLES
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      tc_o
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TC    = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds the number of completed wait cycles in the current REQ cycle
  assign tc_o = (cnt_q == c_TC);

endmodule
`default_nettype wire

// File: rtl/memaccess.sv
`default_nettype none
// ============================================================================
// Module      : memaccess
// Description : swt16 memory-access stage: ALU pass-through and load/store
//               over a req/ack data bus, registered results to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module memaccess #(
  parameter int                      OPCODE_WIDTH    = swt16_pkg::OPCODE_WIDTH,
  parameter int                      PMEM_WORD_WIDTH = swt16_pkg::PMEM_WORD_WIDTH,
  parameter int                      PC_WIDTH        = swt16_pkg::PC_WIDTH,
  parameter int                      IALU_WORD_WIDTH = swt16_pkg::IALU_WORD_WIDTH,
  parameter int                      REG_IDX_WIDTH   = swt16_pkg::REG_IDX_WIDTH,
  parameter int                      DMEM_ADDR_WIDTH = swt16_pkg::DMEM_ADDR_WIDTH,
  parameter int                      DMEM_WORD_WIDTH = swt16_pkg::DMEM_WORD_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] OPC_LOAD        = swt16_pkg::OPC_LOAD,
  parameter logic [OPCODE_WIDTH-1:0] OPC_STORE       = swt16_pkg::OPC_STORE,
  parameter int                      TIMEOUT_CYCLES  = swt16_pkg::TIMEOUT_CYCLES
) (
  input  wire logic                       clock,
  input  wire logic                       reset,
  input  wire logic                       in_valid,
  input  wire logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  wire logic [PC_WIDTH-1:0]        in_pc,
  input  wire logic [IALU_WORD_WIDTH-1:0] in_res,
  input  wire logic [IALU_WORD_WIDTH-1:0] in_store_data,
  input  wire logic                       in_act_write_res_to_reg,
  input  wire logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                            out_stall,
  memaccess_if.master                     dmem,
  output logic                            out_valid,
  output logic                            out_act_write_res_to_reg,
  output logic [PMEM_WORD_WIDTH-1:0]      out_instr,
  output logic [PC_WIDTH-1:0]             out_pc,
  output logic [IALU_WORD_WIDTH-1:0]      out_res,
  output logic [REG_IDX_WIDTH-1:0]        out_res_reg_idx,
  output logic                            out_bus_err
);

  import swt16_pkg::*;

  ma_state_e                  state_q, state_d;
  logic                       req_q, req_d, we_q, we_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DMEM_WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [PMEM_WORD_WIDTH-1:0] mem_instr_q, mem_instr_d;
  logic [PC_WIDTH-1:0]        mem_pc_q, mem_pc_d;
  logic [REG_IDX_WIDTH-1:0]   mem_idx_q, mem_idx_d;
  logic                       out_valid_q, out_valid_d, out_act_q, out_act_d;
  logic [PMEM_WORD_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0]        out_pc_q, out_pc_d;
  logic [IALU_WORD_WIDTH-1:0] out_res_q, out_res_d;
  logic [REG_IDX_WIDTH-1:0]   out_idx_q, out_idx_d;
  logic                       bus_err_q, bus_err_d;

  logic                    w_accept, w_is_load, w_is_store, w_cnt_clr, w_cnt_en, w_tc;
  logic [OPCODE_WIDTH-1:0] w_opcode;

  assign w_opcode   = in_instr[PMEM_WORD_WIDTH-1 -: OPCODE_WIDTH];
  assign w_is_load  = (w_opcode == OPC_LOAD);
  assign w_is_store = (w_opcode == OPC_STORE);
  assign w_accept   = in_valid && (state_q == MA_IDLE);

  memaccess_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr_i (w_cnt_clr),
    .en_i  (w_cnt_en),
    .tc_o  (w_tc)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    mem_idx_d   = mem_idx_q;
    out_valid_d = 1'b0;
    out_act_d   = 1'b0;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_res_d   = out_res_q;
    out_idx_d   = out_idx_q;
    bus_err_d   = bus_err_q;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (w_accept && (w_is_load || w_is_store)) begin
          state_d     = MA_REQ;
          req_d       = 1'b1;
          we_d        = w_is_store;
          addr_d      = in_res[DMEM_ADDR_WIDTH-1:0];
          mem_instr_d = in_instr;
          mem_pc_d    = in_pc;
          mem_idx_d   = in_res_reg_idx;
          w_cnt_clr   = 1'b1;
          if (w_is_store) wdata_d = in_store_data;
        end else if (w_accept) begin
          out_valid_d = 1'b1;
          out_act_d   = in_act_write_res_to_reg;
          out_instr_d = in_instr;
          out_pc_d    = in_pc;
          out_res_d   = in_res;
          out_idx_d   = in_res_reg_idx;
        end
      end
      MA_REQ: begin
        if (dmem.dmem_ack || w_tc) begin
          state_d     = MA_IDLE;
          req_d       = 1'b0;
          out_valid_d = 1'b1;
          out_instr_d = mem_instr_q;
          out_pc_d    = mem_pc_q;
          out_idx_d   = mem_idx_q;
          // Ack wins over a timeout landing in the same cycle
          if (!dmem.dmem_ack) begin
            out_res_d = '0;
            bus_err_d = 1'b1;
          end else if (we_q) begin
            out_res_d = IALU_WORD_WIDTH'(addr_q);
          end else begin
            out_res_d = dmem.dmem_rdata;
            out_act_d = 1'b1;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= MA_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_instr_q <= '0;
      mem_pc_q    <= '0;
      mem_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_act_q   <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_res_q   <= '0;
      out_idx_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
      mem_idx_q   <= mem_idx_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_res_q   <= out_res_d;
      out_idx_q   <= out_idx_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign out_stall                = (state_q == MA_REQ);
  assign dmem.dmem_req            = req_q;
  assign dmem.dmem_we             = we_q;
  assign dmem.dmem_addr           = addr_q;
  assign dmem.dmem_wdata          = wdata_q;
  assign out_valid                = out_valid_q;
  assign out_act_write_res_to_reg = out_act_q;
  assign out_instr                = out_instr_q;
  assign out_pc                   = out_pc_q;
  assign out_res                  = out_res_q;
  assign out_res_reg_idx          = out_idx_q;
  assign out_bus_err              = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memaccess.sv
`default_nettype none
// ============================================================================
// Module      : tb_memaccess
// Description : Directed scoreboard bench for the memaccess stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memaccess;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [11:0] in_pc;
  logic [15:0] in_res;
  logic [15:0] in_store_data;
  logic        in_act;
  logic [3:0]  in_idx;
  logic        out_stall, out_valid, out_act, out_bus_err;
  logic [15:0] out_instr, out_res;
  logic [11:0] out_pc;
  logic [3:0]  out_idx;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  idx;
    logic        act;
    logic [15:0] instr;
    logic [11:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  memaccess_if dmem_bus ();

  memaccess dut (
    .clock                    (clock),
    .reset                    (reset),
    .in_valid                 (in_valid),
    .in_instr                 (in_instr),
    .in_pc                    (in_pc),
    .in_res                   (in_res),
    .in_store_data            (in_store_data),
    .in_act_write_res_to_reg  (in_act),
    .in_res_reg_idx           (in_idx),
    .out_stall                (out_stall),
    .dmem                     (dmem_bus.master),
    .out_valid                (out_valid),
    .out_act_write_res_to_reg (out_act),
    .out_instr                (out_instr),
    .out_pc                   (out_pc),
    .out_res                  (out_res),
    .out_res_reg_idx          (out_idx),
    .out_bus_err              (out_bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one upstream slot and record what writeback should eventually see
  task automatic issue(input logic [15:0] instr, input logic [11:0] pc, input logic [15:0] res,
                       input logic [15:0] sd, input logic [3:0] idx, input logic act,
                       input bit push, input exp_t e);
    in_valid      = 1'b1;
    in_instr      = instr;
    in_pc         = pc;
    in_res        = res;
    in_store_data = sd;
    in_idx        = idx;
    in_act        = act;
    if (push) exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_res",   32'(out_res),   32'(e.res));
          chk("sb_idx",   32'(out_idx),   32'(e.idx));
          chk("sb_act",   32'(out_act),   32'(e.act));
          chk("sb_instr", 32'(out_instr), 32'(e.instr));
          chk("sb_pc",    32'(out_pc),    32'(e.pc));
        end
      end else begin
        chk("bubble_act", 32'(out_act), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    issue({4'h1, 12'h111}, 12'h001, 16'h7777, 16'h0, 4'h6, 1'b1, 1'b0, '0);

    // Reset with an ALU op waiting
    repeat (3) @(negedge clock);
    chk("rst_valid",   32'(out_valid),          32'd0);
    chk("rst_res",     32'(out_res),            32'd0);
    chk("rst_act",     32'(out_act),            32'd0);
    chk("rst_instr",   32'(out_instr),          32'd0);
    chk("rst_stall",   32'(out_stall),          32'd0);
    chk("rst_req",     32'(dmem_bus.dmem_req),  32'd0);
    chk("rst_bus_err", 32'(out_bus_err),        32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clock);

    // ALU pass-through
    issue({4'h1, 12'h234}, 12'h010, 16'h1234, 16'h0, 4'd3, 1'b1, 1'b1,
          '{res: 16'h1234, idx: 4'd3, act: 1'b1, instr: {4'h1, 12'h234}, pc: 12'h010});
    @(negedge clock);
    in_valid = 1'b0;
    chk("alu_stall", 32'(out_stall), 32'd0);

    // Load with ack in the 4th REQ cycle
    issue({4'hA, 12'h005}, 12'h020, 16'hF0A5, 16'h0, 4'd5, 1'b0, 1'b1,
          '{res: 16'hBEEF, idx: 4'd5, act: 1'b1, instr: {4'hA, 12'h005}, pc: 12'h020});
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clock);
      chk("ld_stall", 32'(out_stall),           32'd1);
      chk("ld_req",   32'(dmem_bus.dmem_req),   32'd1);
      chk("ld_addr",  32'(dmem_bus.dmem_addr),  32'h0A5);
      chk("ld_we",    32'(dmem_bus.dmem_we),    32'd0);
      if (i == 4) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 16'hBEEF;
      end
    end
    @(negedge clock);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    chk("ld_done_stall", 32'(out_stall),         32'd0);
    chk("ld_done_req",   32'(dmem_bus.dmem_req), 32'd0);

    // Store with ack in the first REQ cycle
    issue({4'hB, 12'h000}, 12'h030, 16'h0010, 16'h5555, 4'd7, 1'b1, 1'b1,
          '{res: 16'h0010, idx: 4'd7, act: 1'b0, instr: {4'hB, 12'h000}, pc: 12'h030});
    @(negedge clock);
    in_valid = 1'b0;
    chk("st_req",   32'(dmem_bus.dmem_req),   32'd1);
    chk("st_we",    32'(dmem_bus.dmem_we),    32'd1);
    chk("st_wdata", 32'(dmem_bus.dmem_wdata), 32'h5555);
    chk("st_addr",  32'(dmem_bus.dmem_addr),  32'h010);
    dmem_bus.dmem_ack = 1'b1;
    @(negedge clock);
    dmem_bus.dmem_ack = 1'b0;
    chk("st_done_req", 32'(dmem_bus.dmem_req), 32'd0);

    // Load that never gets an ack
    issue({4'hA, 12'h001}, 12'h040, 16'h0123, 16'h0, 4'd9, 1'b1, 1'b1,
          '{res: 16'h0000, idx: 4'd9, act: 1'b0, instr: {4'hA, 12'h001}, pc: 12'h040});
    @(negedge clock);
    in_valid = 1'b0;
    chk("to_err_pre", 32'(out_bus_err), 32'd0);
    n = 0;
    while (dmem_bus.dmem_req && n < 300) begin
      n++;
      @(negedge clock);
    end
    chk("to_req_cycles", 32'(n),                  32'd255);
    chk("to_req",        32'(dmem_bus.dmem_req),  32'd0);
    chk("to_err",        32'(out_bus_err),        32'd1);
    issue({4'h2, 12'h0AB}, 12'h050, 16'hABCD, 16'h0, 4'd2, 1'b1, 1'b1,
          '{res: 16'hABCD, idx: 4'd2, act: 1'b1, instr: {4'h2, 12'h0AB}, pc: 12'h050});
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("to_err_held", 32'(out_bus_err), 32'd1);

    // Reset two cycles into a pending load, then a stray ack
    issue({4'hA, 12'h002}, 12'h060, 16'h0050, 16'h0, 4'd4, 1'b1, 1'b0, '0);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("rt_req_before", 32'(dmem_bus.dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rt_req_async",   32'(dmem_bus.dmem_req), 32'd0);
    chk("rt_stall_async", 32'(out_stall),         32'd0);
    @(negedge clock);
    reset               = 1'b0;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 16'hDEAD;
    repeat (3) begin
      @(negedge clock);
      chk("rt_no_valid", 32'(out_valid),         32'd0);
      chk("rt_no_req",   32'(dmem_bus.dmem_req), 32'd0);
    end
    dmem_bus.dmem_ack = 1'b0;
    chk("rt_err_cleared", 32'(out_bus_err), 32'd0);

    repeat (2) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memaccess.md
Name: memaccess

Overview:
- Pipeline stage directly upstream of writeback in the swt16 core.
- Receives execute results and performs load/store transactions on the data-memory bus using a req/ack handshake. Stalls upstream while a transaction is outstanding.
- Presents a registered result, destination register index and write-enable to writeback, together with the instr/pc tags that writeback samples.

Parameters:
- OPCODE_WIDTH, 4, opcode field width (instr MSBs)
- PMEM_WORD_WIDTH, 16, instruction word width
- PC_WIDTH, 12, program counter width
- IALU_WORD_WIDTH, 16, ALU result / register word width
- REG_IDX_WIDTH, 4, register index width
- DMEM_ADDR_WIDTH, 12, data memory address width
- DMEM_WORD_WIDTH, 16, data memory word width (equal to IALU_WORD_WIDTH)
- OPC_LOAD, 4'hA, load opcode
- OPC_STORE, 4'hB, store opcode
- TIMEOUT_CYCLES, 255, max wait cycles for dmem_ack (1..255)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream slot holds a valid instruction
- in_instr  in  PMEM_WORD_WIDTH  instruction word; opcode = in_instr[PMEM_WORD_WIDTH-1 -: OPCODE_WIDTH]
- in_pc  in  PC_WIDTH  instruction PC
- in_res  in  IALU_WORD_WIDTH  ALU result; this is the address for load/store
- in_store_data  in  IALU_WORD_WIDTH  store data
- in_act_write_res_to_reg  in  1  instruction writes a register
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register
- out_stall  out  1  upstream must hold; no input is accepted
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DMEM_ADDR_WIDTH  bus address
- dmem_wdata  out  DMEM_WORD_WIDTH  write data
- dmem_rdata  in  DMEM_WORD_WIDTH  read data, valid with dmem_ack
- dmem_ack  in  1  transaction complete
- out_valid  out  1  output slot valid
- out_act_write_res_to_reg  out  1  to writeback
- out_instr  out  PMEM_WORD_WIDTH  to writeback
- out_pc  out  PC_WIDTH  to writeback
- out_res  out  IALU_WORD_WIDTH  to writeback
- out_res_reg_idx  out  REG_IDX_WIDTH  to writeback
- out_bus_err  out  1  sticky: an access timed out

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 including dmem_req, out_stall and out_bus_err; wait counter 0.
- FSM states: IDLE and REQ. out_stall = (state==REQ). Input is accepted on a rising edge when in_valid=1 and out_stall=0.
- Non-memory op accepted in IDLE:
  - 1-cycle registered pass-through: out_valid=1; out_res, out_res_reg_idx, out_act_write_res_to_reg, out_instr and out_pc take the input values.
  - State stays IDLE.
- No accept in IDLE: out_valid=0 and out_act_write_res_to_reg=0 (bubble). Other outputs hold their values.
- Load/store accepted in IDLE:
  - Latch instr, pc, reg_idx, dmem_addr=in_res[DMEM_ADDR_WIDTH-1:0] (upper bits dropped), dmem_wdata=in_store_data (store only), dmem_we=(opcode==OPC_STORE).
  - Set dmem_req=1 and go to REQ. Counter cleared.
  - Next output is a bubble.
- In REQ:
  - dmem_req, dmem_addr, dmem_we and dmem_wdata are held stable. The counter increments each cycle without ack.
- dmem_ack=1 in REQ:
  - Next edge: dmem_req=0, state IDLE, out_valid=1.
  - Load: out_res=dmem_rdata and out_act_write_res_to_reg=1 (load dest reg, including reg 0).
  - Store: out_res=address zero-extended and out_act_write_res_to_reg=0.
  - The ack cycle itself still has out_stall=1. The earliest new accept is the cycle after the return to IDLE.
- Timeout: counter reaches TIMEOUT_CYCLES with no ack → complete as for ack, but with out_act_write_res_to_reg=0 and out_res=0. out_bus_err is set to 1 and held until reset.
- dmem_ack outside REQ is ignored.
- Reset asserted in REQ aborts the transaction: dmem_req drops asynchronously and no output is produced.
- Latency: non-memory op 1 cycle; memory op 2 + ack-wait cycles (minimum 2, ack in the first REQ cycle).

Decomposition:
- Shared package swt16_pkg holds:
  - opcode constants OPC_LOAD/OPC_STORE
  - memaccess state encoding (IDLE=0, REQ=1)
  - width constants shared with the execute and writeback stages
- One sub-module, memaccess_timeout: clear/enable counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset with in_valid=1 and an ALU op present → all outputs 0, no accept until reset released.
- ALU op (opcode 4'h1, res=16'h1234, idx=3, act=1) → next cycle out_valid=1, out_res=16'h1234, out_res_reg_idx=3, out_act=1, out_stall=0.
- Load (opcode 4'hA, res=16'hF0A5, idx=5), ack after 3 REQ cycles with rdata=16'hBEEF:
  - dmem_addr=12'h0A5, dmem_we=0, out_stall high 4 cycles.
  - Then out_res=16'hBEEF, out_act=1, out_res_reg_idx=5.
- Store (opcode 4'hB, res=16'h0010, store_data=16'h5555), ack in the first REQ cycle:
  - dmem_we=1, dmem_wdata=16'h5555.
  - out_valid=1, out_act=0, two-cycle latency.
- Load with no ack → after 255 REQ cycles dmem_req=0, out_act=0, out_res=0, out_bus_err=1 and held. A following ALU op completes normally.
- Reset pulse 2 cycles into a pending load → dmem_req drops in the same cycle, state IDLE. A late dmem_ack is ignored and out_valid stays 0.
